// File: rtl/if_id_fifo_pkg.sv
// Shared widths and the IF->ID bundle type.
// Defaults mirror the core's address/instruction widths.
package if_id_fifo_pkg;

  localparam int AddrLen  = 32;
  localparam int InstLen  = 32;
  localparam int DefDepth = 4;

  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef struct packed {
    logic [AddrLen-1:0] pc;
    logic [InstLen-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/if_id_fifo_if.sv
// Fetch/decode handshake bundle around the IF->ID queue.
// The master drives fetch data and decode ready; the slave is the queue.
interface if_id_fifo_if
  import if_id_fifo_pkg::*;
#(
  parameter int ADDR_W = AddrLen,
  parameter int INST_W = InstLen,
  parameter int DEPTH  = DefDepth
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [PTR_W:0]    count;

  modport master (
    output if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, count
  );

  modport slave (
    input  if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_inst, count
  );

endinterface

// File: rtl/if_id_fifo_mem.sv
// Queue storage: one write port, one asynchronous read port.
// Cleared on reset so the idle read value is deterministic.
module if_id_fifo_mem #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_fifo.sv
// IF->ID decoupling queue: DEPTH {pc,inst} pairs, one-cycle latency.
// Ready/valid come from registered count only; flush beats rdy.
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter int ADDR_W = AddrLen,
  parameter int INST_W = InstLen,
  parameter int DEPTH  = DefDepth
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        flush,
  if_id_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int W     = ADDR_W + INST_W;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic [W-1:0]     rdata;

  assign bus.if_ready = (count_q != FULL);
  assign bus.id_valid = (count_q != '0);
  assign bus.count    = count_q;

  assign push = rdy & bus.if_valid & bus.if_ready;
  assign pop  = rdy & bus.id_valid & bus.id_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      flush: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      default: begin
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.if_pc, bus.if_inst}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Stale slots stay in memory after pops/flush; hide them when empty.
  assign bus.id_pc   = bus.id_valid ? rdata[W-1:INST_W] : '0;
  assign bus.id_inst = bus.id_valid ? rdata[INST_W-1:0] : '0;

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && count_q == FULL));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop && count_q == '0));
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// Randomised and directed bench for if_id_fifo.
// Queue-based reference model plus literal spot checks.
module tb_if_id_fifo;
  import if_id_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic rdy;
  logic flush;

  int vectors;
  int errors;

  if_id_t mq[$];

  if_id_fifo_if #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) bus ();

  if_id_fifo #(
    .ADDR_W (32),
    .INST_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc * 3 + 32'h13;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: occupancy and ordering only, via a plain queue.
  always @(posedge clk) begin : model
    bit m_push;
    bit m_pop;
    if_id_t e;
    if (rst_n) begin
      m_push = rdy && bus.if_valid && (mq.size() != DEPTH);
      m_pop  = rdy && bus.id_ready && (mq.size() != 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          e.pc   = bus.if_pc;
          e.inst = bus.if_inst;
          mq.push_back(e);
        end
      end
    end
  end

  always @(negedge rst_n) mq.delete();

  always @(negedge clk) begin : compare
    logic [31:0] epc;
    logic [31:0] einst;
    if (rst_n) begin
      epc   = (mq.size() != 0) ? mq[0].pc   : 32'h0;
      einst = (mq.size() != 0) ? mq[0].inst : 32'h0;
      chk("m_count",    64'(bus.count),    64'(mq.size()));
      chk("m_id_valid", 64'(bus.id_valid), 64'(mq.size() != 0));
      chk("m_if_ready", 64'(bus.if_ready), 64'(mq.size() != DEPTH));
      chk("m_id_pc",    64'(bus.id_pc),    64'(epc));
      chk("m_id_inst",  64'(bus.id_inst),  64'(einst));
    end
  end

  // Set inputs, let one rising edge act on them, return 2 time units later.
  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic r, input logic rd,
                       input logic fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = mk_inst(pc);
    rdy          = r;
    bus.id_ready = rd;
    flush        = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_state(input string nm, input int c,
                           input logic [31:0] pc);
    chk({nm, "_count"}, 64'(bus.count), 64'(c));
    chk({nm, "_pc"},    64'(bus.id_pc), 64'(pc));
  endtask

  logic [31:0] order [4];

  initial begin
    vectors      = 0;
    errors       = 0;
    rst_n        = 1'b0;
    rdy          = 1'b1;
    flush        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_inst  = '0;
    bus.id_ready = 1'b0;

    #3;
    chk("por_count",    64'(bus.count),    64'd0);
    chk("por_if_ready", 64'(bus.if_ready), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Reset mid-cycle with three entries held.
    drive(1, 32'h100, 1, 0, 0);
    drive(1, 32'h104, 1, 0, 0);
    drive(1, 32'h108, 1, 0, 0);
    bus.if_valid = 1'b0;
    chk_state("pre_rst", 3, 32'h100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_count",    64'(bus.count),    64'd0);
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_pc",    64'(bus.id_pc),    64'd0);
    chk("rst_id_inst",  64'(bus.id_inst),  64'd0);
    chk("rst_if_ready", 64'(bus.if_ready), 64'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Fill, then an ignored fifth push.
    drive(1, 32'h0, 1, 0, 0);
    drive(1, 32'h4, 1, 0, 0);
    drive(1, 32'h8, 1, 0, 0);
    drive(1, 32'hC, 1, 0, 0);
    chk_state("fill", 4, 32'h0);
    chk("fill_if_ready", 64'(bus.if_ready), 64'd0);
    chk("fill_inst", 64'(bus.id_inst), 64'(mk_inst(32'h0)));
    drive(1, 32'h10, 1, 0, 0);
    chk_state("fill5", 4, 32'h0);

    // Drain two, refill across the wrap, drain all in order.
    drive(0, 32'h0, 1, 1, 0);
    drive(0, 32'h0, 1, 1, 0);
    chk_state("drain2", 2, 32'h8);
    drive(1, 32'h10, 1, 0, 0);
    drive(1, 32'h14, 1, 0, 0);
    chk_state("wrap", 4, 32'h8);
    order = '{32'h8, 32'hC, 32'h10, 32'h14};
    for (int i = 0; i < 4; i++) begin
      chk("order_pc", 64'(bus.id_pc), 64'(order[i]));
      drive(0, 32'h0, 1, 1, 0);
    end
    chk_state("empty", 0, 32'h0);

    // Concurrent push and pop, then at full.
    drive(1, 32'h18, 1, 0, 0);
    drive(1, 32'h1C, 1, 0, 0);
    drive(1, 32'h20, 1, 1, 0);
    chk_state("pp2", 2, 32'h1C);
    drive(1, 32'h24, 1, 0, 0);
    drive(1, 32'h28, 1, 0, 0);
    chk_state("full", 4, 32'h1C);
    drive(1, 32'h2C, 1, 1, 0);
    chk_state("pp_full", 3, 32'h20);

    // Flush overrides push, pop and a frozen pipeline.
    drive(1, 32'h30, 0, 1, 1);
    chk_state("flush", 0, 32'h0);
    chk("flush_id_valid", 64'(bus.id_valid), 64'd0);

    // Freeze for three cycles, then resume.
    drive(1, 32'h30, 1, 0, 0);
    drive(1, 32'h34, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 32'h40, 0, 1, 0);
    chk_state("frozen", 2, 32'h30);
    drive(1, 32'h38, 1, 1, 0);
    chk_state("resume", 2, 32'h34);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1,
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
    end

    drive(0, 32'h0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
